// File: rtl/float_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// helpers deriving packed-word geometry from the exponent/mantissa sizes.
package float_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int float_size(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/float_classify.sv
// Splits a packed float into fields and classifies it; subnormals count as zero.
module float_classify
  import float_pkg::*;
#(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23
) (
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] f_i,
  output cls_e                                 cls_o,
  output logic                                 sign_o,
  output logic [EXPONENT_SIZE-1:0]             exp_o,
  output logic [MANTISSA_SIZE-1:0]             man_o
);

  assign sign_o = f_i[EXPONENT_SIZE+MANTISSA_SIZE];
  assign exp_o  = f_i[EXPONENT_SIZE+MANTISSA_SIZE-1:MANTISSA_SIZE];
  assign man_o  = f_i[MANTISSA_SIZE-1:0];

  always_comb begin
    cls_o = CLS_NORMAL;
    if (exp_o == '0)
      cls_o = CLS_ZERO;
    else if (&exp_o)
      cls_o = (man_o == '0) ? CLS_INF : CLS_NAN;
  end

endmodule

// File: rtl/float_mul_stream.sv
// Three-stage streaming float multiplier with RNE rounding, special values,
// exception flags, sideband tag and full valid/ready backpressure.
module float_mul_stream
  import float_pkg::*;
#(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] s_facA,
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] s_facB,
  input  logic [TAG_WIDTH-1:0]                 s_tag,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] m_prod,
  output logic [TAG_WIDTH-1:0]                 m_tag,
  output logic [FLAG_W-1:0]                    m_flags
);

  localparam int M  = MANTISSA_SIZE;
  localparam int E  = EXPONENT_SIZE;
  localparam int FS = float_size(E, M);
  localparam int PW = 2 * (M + 1);
  localparam int EW = E + 2;
  localparam logic signed [EW-1:0] BIAS_S    = EW'(exp_bias(E));
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << E) - 1);
  localparam logic signed [EW-1:0] ONE_S     = EW'(1);
  localparam logic [E-1:0]         EXP_ONES  = '1;
  localparam logic [FS-1:0]        QNAN      = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

  function automatic logic [M+1:0] round_rne(input logic [M:0] man, input logic grd,
                                             input logic stk);
    return {1'b0, man} + {{(M+1){1'b0}}, grd & (stk | man[0])};
  endfunction

  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic en_p1, en_p2, en_p3;

  assign en_p3   = !vld_p3_q || m_ready;
  assign en_p2   = !vld_p2_q || en_p3;
  assign en_p1   = !vld_p1_q || en_p2;
  assign s_ready = en_p1;
  assign m_valid = vld_p3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      if (en_p1) vld_p1_q <= s_valid;
      if (en_p2) vld_p2_q <= vld_p1_q;
      if (en_p3) vld_p3_q <= vld_p2_q;
    end
  end

  // ---- S1: unpack, classify, mantissa product, exponent sum
  cls_e                    cls_a, cls_b, cls_p1_d, cls_p1_q;
  logic                    sgn_a, sgn_b, sgn_p1_d, sgn_p1_q;
  logic [E-1:0]            exp_a, exp_b;
  logic [M-1:0]            man_a, man_b;
  logic [PW-1:0]           prod_p1_d, prod_p1_q;
  logic signed [EW-1:0]    exp_p1_d, exp_p1_q;
  logic [TAG_WIDTH-1:0]    tag_p1_q;

  float_classify #(.EXPONENT_SIZE(E), .MANTISSA_SIZE(M)) u_cls_a (
    .f_i(s_facA), .cls_o(cls_a), .sign_o(sgn_a), .exp_o(exp_a), .man_o(man_a)
  );
  float_classify #(.EXPONENT_SIZE(E), .MANTISSA_SIZE(M)) u_cls_b (
    .f_i(s_facB), .cls_o(cls_b), .sign_o(sgn_b), .exp_o(exp_b), .man_o(man_b)
  );

  always_comb begin
    cls_p1_d = CLS_NORMAL;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_ZERO && cls_b == CLS_INF) || (cls_a == CLS_INF && cls_b == CLS_ZERO))
      cls_p1_d = CLS_NAN;
    else if (cls_a == CLS_INF || cls_b == CLS_INF)
      cls_p1_d = CLS_INF;
    else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
      cls_p1_d = CLS_ZERO;
  end

  assign sgn_p1_d  = sgn_a ^ sgn_b;
  assign prod_p1_d = PW'({1'b1, man_a}) * PW'({1'b1, man_b});
  assign exp_p1_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;

  // ---- S2: normalise to a 1.x mantissa, form guard and sticky
  cls_e                 cls_p2_q;
  logic                 sgn_p2_q;
  logic [M:0]           man_p2_d, man_p2_q;
  logic                 grd_p2_d, grd_p2_q, stk_p2_d, stk_p2_q;
  logic signed [EW-1:0] exp_p2_d, exp_p2_q;
  logic [TAG_WIDTH-1:0] tag_p2_q;

  always_comb begin
    if (prod_p1_q[PW-1]) begin
      man_p2_d = prod_p1_q[PW-1:M+1];
      grd_p2_d = prod_p1_q[M];
      stk_p2_d = |prod_p1_q[M-1:0];
      exp_p2_d = exp_p1_q + ONE_S;
    end else begin
      man_p2_d = prod_p1_q[PW-2:M];
      grd_p2_d = prod_p1_q[M-1];
      stk_p2_d = |prod_p1_q[M-2:0];
      exp_p2_d = exp_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en_p1) begin
      cls_p1_q  <= cls_p1_d;
      sgn_p1_q  <= sgn_p1_d;
      prod_p1_q <= prod_p1_d;
      exp_p1_q  <= exp_p1_d;
      tag_p1_q  <= s_tag;
    end
    if (en_p2) begin
      cls_p2_q <= cls_p1_q;
      sgn_p2_q <= sgn_p1_q;
      man_p2_q <= man_p2_d;
      grd_p2_q <= grd_p2_d;
      stk_p2_q <= stk_p2_d;
      exp_p2_q <= exp_p2_d;
      tag_p2_q <= tag_p1_q;
    end
  end

  // ---- S3: round, clamp to Inf/zero, pack into the output register
  logic [M+1:0]         man_rnd;
  logic [M-1:0]         frac_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic [FS-1:0]        prod_p3_d, prod_p3_q;
  logic [FLAG_W-1:0]    flags_p3_d, flags_p3_q;
  logic [TAG_WIDTH-1:0] tag_p3_q;

  assign man_rnd  = round_rne(man_p2_q, grd_p2_q, stk_p2_q);
  assign exp_rnd  = man_rnd[M+1] ? exp_p2_q + ONE_S : exp_p2_q;
  assign frac_rnd = man_rnd[M+1] ? man_rnd[M:1] : man_rnd[M-1:0];

  always_comb begin
    prod_p3_d  = '0;
    flags_p3_d = '0;
    case (cls_p2_q)
      CLS_NAN: begin
        prod_p3_d                = QNAN;
        flags_p3_d[FLAG_INVALID] = 1'b1;
      end
      CLS_INF:  prod_p3_d = {sgn_p2_q, EXP_ONES, {M{1'b0}}};
      CLS_ZERO: prod_p3_d = {sgn_p2_q, {(FS-1){1'b0}}};
      default: begin
        if (exp_rnd >= EXP_MAX_S) begin
          prod_p3_d                 = {sgn_p2_q, EXP_ONES, {M{1'b0}}};
          flags_p3_d[FLAG_OVERFLOW] = 1'b1;
          flags_p3_d[FLAG_INEXACT]  = 1'b1;
        end else if (exp_rnd[EW-1] || exp_rnd == '0) begin
          prod_p3_d                  = {sgn_p2_q, {(FS-1){1'b0}}};
          flags_p3_d[FLAG_UNDERFLOW] = 1'b1;
          flags_p3_d[FLAG_INEXACT]   = 1'b1;
        end else begin
          prod_p3_d                = {sgn_p2_q, exp_rnd[E-1:0], frac_rnd};
          flags_p3_d[FLAG_INEXACT] = grd_p2_q | stk_p2_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_p3_q  <= '0;
      flags_p3_q <= '0;
      tag_p3_q   <= '0;
    end else if (en_p3) begin
      prod_p3_q  <= prod_p3_d;
      flags_p3_q <= flags_p3_d;
      tag_p3_q   <= tag_p2_q;
    end
  end

  assign m_prod  = prod_p3_q;
  assign m_flags = flags_p3_q;
  assign m_tag   = tag_p3_q;

endmodule

// File: doc/float_mul_stream.md
Name: float_mul_stream

Overview:
- Pipelined IEEE-754-style floating-point multiplier with valid/ready handshake on both sides, next generation of the fixed-latency multiplier.
- Adds round-to-nearest-even, full special-value handling (NaN/Inf/zero), exception flags, a sideband tag and full backpressure.
- Sits between stream producers (vertex/matrix units) and consumers that may stall.

Parameters:
- MANTISSA_SIZE, 23, stored mantissa bits (hidden bit excluded).
- EXPONENT_SIZE, 8, exponent bits; bias = 2^(EXPONENT_SIZE-1)-1.
- TAG_WIDTH, 4, sideband tag width carried alongside each operation (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  block accepts operands this cycle.
- s_facA  in  FLOAT_SIZE  operand A (FLOAT_SIZE = 1+EXPONENT_SIZE+MANTISSA_SIZE).
- s_facB  in  FLOAT_SIZE  operand B.
- s_tag  in  TAG_WIDTH  user tag.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts result.
- m_prod  out  FLOAT_SIZE  product.
- m_tag  out  TAG_WIDTH  tag of this product.
- m_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (async assert, sync release):
  - All stage valids clear; m_valid=0, m_prod=0, m_tag=0, m_flags=0.
  - s_ready=1 after reset.
  - Reset mid-operation discards all in-flight items.
- Handshake:
  - Transfer on valid&&ready.
  - m_valid/m_prod/m_tag/m_flags stay stable while m_valid && !m_ready.
  - s_ready must not depend combinationally on s_valid.
- Pipeline: 3 registered stages, each with its own valid bit.
  - S1: unpack, classify, mantissa product, exponent sum (EXPONENT_SIZE+2 bits, signed).
  - S2: normalise (shift right 1 if product MSB set, exponent+1), form guard and sticky.
  - S3: round, overflow/underflow clamp, pack. Output register = S3.
  - A stage loads when it is empty or its content advances this cycle.
  - s_ready = !S1.valid || S1 advances. Stalls propagate back through the chain; no bubbles when m_ready=1.
  - Latency is exactly 3 cycles from accept to m_valid with m_ready held 1. Throughput is 1/cycle.
  - Up to 3 items are buffered when stalled; results stay in order and none are lost or duplicated.
- Subnormals:
  - Inputs with exponent 0 are treated as signed zero (flush).
  - Results below the minimum normal flush to signed zero, with underflow=1 and inexact=1 when the exact result is non-zero.
- Special cases (flags apply to that result only):
  - Either operand NaN, or 0*Inf: canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0); invalid=1.
  - Inf*nonzero finite or Inf*Inf: Inf, sign = xor of signs; no flags.
  - Zero*finite: zero, sign = xor of signs.
- Rounding: round-to-nearest-even on the 2*(MANTISSA_SIZE+1)-bit product using guard and sticky.
  - Mantissa carry-out after rounding increments the exponent.
  - inexact=1 if guard|sticky.
- Overflow: biased exponent after rounding >= all-ones gives signed Inf; overflow=1, inexact=1.
- Sign: always xor of the operand signs, except for NaN.

Decomposition:
- Shared package float_pkg: derived FLOAT_SIZE, bias, all-ones exponent, canonical qNaN constant, flag bit indices, classify encoding (zero/normal/inf/nan).
- Sub-module float_classify: combinational, one instance per operand in S1; reusable by the adder.
- Rounding/pack stays inline.

Test Plan:
- 0x3FC00000 * 0x40000000, m_ready=1 -> m_prod=0x40400000 exactly 3 cycles after accept, flags=0.
- RNE tie: 0x3F800800 * 0x3F800800 -> 0x3F801000, inexact=1. Also 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1. 0xFF800000 * 0x40000000 -> 0xFF800000, flags=0.
- Overflow/underflow:
  - 0x7F000000 * 0x40000000 -> 0x7F800000, overflow=1, inexact=1.
  - 0x80800000 * 0x3F000000 -> 0x80000000, underflow=1, inexact=1.
- Backpressure: m_ready=0, offer 5 back-to-back pairs with tags 0..4 -> s_ready drops after 3 accepts. Raise m_ready -> all 5 results emerge in tag order, none lost, outputs stable while stalled.
- Assert reset with 2 items in flight -> m_valid=0 immediately (async). After release, s_ready=1 and the next result is correct.
